// File: rtl/sink_id_arbiter_pkg.sv
// Shared types for the sink ID arbiter: default ID width, ID type and FSM states.
package tidc_sink_pkg;

    localparam int SINK_ID_W = 4;

    typedef logic [SINK_ID_W-1:0] sink_id_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } sink_arb_state_e;

endpackage

// File: rtl/sink_id_arbiter_if.sv
// Bundle of requester, free-path and allocator handshake signals for the sink ID arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface sink_id_arbiter_if import tidc_sink_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = SINK_ID_W
);

    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ-1:0]         gnt;
    logic [ID_W-1:0]            gnt_sink_id;
    logic                       free_valid;
    logic [ID_W-1:0]            free_sink_id;
    logic [$clog2(NUM_REQ)-1:0] free_src;
    logic                       alloc_req;
    logic                       alloc_gnt;
    logic [ID_W-1:0]            alloc_sink_id;
    logic                       dealloc_req;
    logic [ID_W-1:0]            dealloc_sink_id;
    logic [ID_W:0]              outstanding;
    logic                       err_free;

    modport slave (
        input  req, free_valid, free_sink_id, free_src, alloc_gnt, alloc_sink_id,
        output gnt, gnt_sink_id, alloc_req, dealloc_req, dealloc_sink_id, outstanding, err_free
    );

    modport master (
        output req, free_valid, free_sink_id, free_src, alloc_gnt, alloc_sink_id,
        input  gnt, gnt_sink_id, alloc_req, dealloc_req, dealloc_sink_id, outstanding, err_free
    );

endinterface

// File: rtl/sink_id_arbiter_rr_arbiter.sv
// Combinational round-robin picker: scans the request vector starting at the
// pointer, wrapping modulo NUM_REQ, and reports the first hit.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [PTR_W-1:0]   win_idx,
    output logic               any_win
);

    logic [PTR_W-1:0] cand;

    // Walk the requesters from the pointer onward and keep the first one found.
    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        any_win    = 1'b0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (!any_win && req[cand]) begin
                any_win          = 1'b1;
                win_idx          = cand;
                win_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sink_id_arbiter.sv
// Round-robin arbiter sharing one sink ID allocator among NUM_REQ requesters.
// Sequences IDLE -> REQ -> WAIT per allocation, forwards frees to the allocator
// and tracks outstanding IDs so the allocator is never asked when exhausted.
// Optional macro SINK_ARB_OWNER_CHECK_EN adds a per-ID owner table that flags
// frees from the wrong requester.
module sink_id_arbiter import tidc_sink_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = SINK_ID_W
) (
    input  logic               clk,
    input  logic               rst,
    sink_id_arbiter_if.slave   bus
);

    localparam int              PTR_W    = $clog2(NUM_REQ);
    localparam int              POOL     = 2**ID_W;
    localparam logic [ID_W:0]   POOL_CNT = (ID_W+1)'(POOL);
    localparam logic [ID_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    sink_arb_state_e    state;
    sink_arb_state_e    state_next;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   winner_q;
    logic [NUM_REQ-1:0] winner_oh_q;
    logic [ID_W-1:0]    id_q;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] arb_onehot;
    logic [PTR_W-1:0]   arb_idx;
    logic               arb_any;
    logic               gnt_any;
    logic               not_full;
    logic               start_arb;
    logic               grant_now;
    logic               free_ok;
    logic               owner_bad;

    // A requester whose grant pulse is out this cycle is masked from the next pick.
    assign eligible = bus.req & ~bus.gnt;
    assign gnt_any  = |bus.gnt;
    assign free_ok  = bus.free_valid && (bus.outstanding != '0);

    // The grant currently on the bus is not yet in the counter, so count it here.
    assign not_full = gnt_any ? (bus.outstanding < (POOL_CNT - CNT_ONE))
                              : (bus.outstanding < POOL_CNT);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req        (eligible),
        .ptr        (ptr_q),
        .win_onehot (arb_onehot),
        .win_idx    (arb_idx),
        .any_win    (arb_any)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic; a missing alloc_gnt in WAIT simply drops back to IDLE for a retry.
    always_comb begin
        state_next = state;
        start_arb  = 1'b0;
        grant_now  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_any && not_full) begin
                    start_arb  = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                grant_now  = bus.alloc_gnt;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Winner latch, allocated ID capture and pointer advance on a completed grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            winner_q    <= '0;
            winner_oh_q <= '0;
            id_q        <= '0;
            ptr_q       <= '0;
        end else begin
            if (start_arb) begin
                winner_q    <= arb_idx;
                winner_oh_q <= arb_onehot;
            end
            if (state == ST_REQ) begin
                id_q <= bus.alloc_sink_id;
            end
            if (grant_now) begin
                ptr_q <= (winner_q == LAST_IDX) ? '0 : winner_q + PTR_ONE;
            end
        end
    end

    // Registered grant pulse and allocator request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.gnt         <= '0;
            bus.gnt_sink_id <= '0;
            bus.alloc_req   <= 1'b0;
        end else begin
            bus.gnt         <= grant_now ? winner_oh_q : '0;
            bus.gnt_sink_id <= grant_now ? id_q : '0;
            bus.alloc_req   <= (state_next == ST_REQ);
        end
    end

    // Frees pass straight through to the allocator one cycle later, independent of the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dealloc_req     <= 1'b0;
            bus.dealloc_sink_id <= '0;
        end else begin
            bus.dealloc_req <= bus.free_valid;
            if (bus.free_valid) begin
                bus.dealloc_sink_id <= bus.free_sink_id;
            end
        end
    end

    // Outstanding ID count (saturating at zero) and sticky illegal-free flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.outstanding <= '0;
            bus.err_free    <= 1'b0;
        end else begin
            case ({gnt_any, free_ok})
                2'b10:   bus.outstanding <= bus.outstanding + CNT_ONE;
                2'b01:   bus.outstanding <= bus.outstanding - CNT_ONE;
                default: bus.outstanding <= bus.outstanding;
            endcase
            if ((bus.free_valid && (bus.outstanding == '0)) || owner_bad) begin
                bus.err_free <= 1'b1;
            end
        end
    end

`ifdef SINK_ARB_OWNER_CHECK_EN
    logic [PTR_W-1:0] owner_idx [POOL];
    logic [POOL-1:0]  owner_vld;

    assign owner_bad = bus.free_valid &&
                       !(owner_vld[bus.free_sink_id] &&
                         (owner_idx[bus.free_sink_id] == bus.free_src));

    // Owner table: a grant claims its ID entry, a free releases it; the claim wins on a clash.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_vld <= '0;
            for (int i = 0; i < POOL; i++) begin
                owner_idx[i] <= '0;
            end
        end else begin
            if (bus.free_valid) begin
                owner_vld[bus.free_sink_id] <= 1'b0;
            end
            if (grant_now) begin
                owner_vld[id_q] <= 1'b1;
                owner_idx[id_q] <= winner_q;
            end
        end
    end
`else
    logic free_src_unused;

    assign owner_bad       = 1'b0;
    assign free_src_unused = ^bus.free_src;
`endif

endmodule

// File: tb/tb_sink_id_arbiter.sv
// Directed testbench for sink_id_arbiter with a one-cycle-latency allocator responder.
module tb_sink_id_arbiter;
    import tidc_sink_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic resp_prev;

    sink_id_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    sink_id_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Allocator model: alloc_gnt answers an alloc_req one cycle later.
    initial begin
        resp_prev     = 1'b0;
        bus.alloc_gnt = 1'b0;
        forever begin
            @(negedge clk);
            bus.alloc_gnt = resp_prev;
            resp_prev     = bus.alloc_req;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst              = 1'b1;
        bus.req          = '0;
        bus.free_valid   = 1'b0;
        bus.free_sink_id = '0;
        bus.free_src     = '0;
        bus.alloc_sink_id = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Hold mask until n grants arrive; returns in the cycle of the last gnt pulse.
    task automatic do_grants(input int n, input logic [3:0] mask, input sink_id_t first_id, output int got);
        sink_id_t id;
        id = first_id;
        bus.req = mask;
        bus.alloc_sink_id = id;
        got = 0;
        for (int c = 0; c < n * 5 + 10 && got < n; c++) begin
            tick();
            if (bus.gnt != '0) begin
                got++;
                id = id + 4'd1;
                bus.alloc_sink_id = id;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("[TB] FAIL reset_gnt got=%b exp=0000", bus.gnt); end
        checks++; if (bus.gnt_sink_id !== 4'd0) begin failures++; $display("[TB] FAIL reset_gnt_sink_id got=%0d exp=0", bus.gnt_sink_id); end
        checks++; if (bus.alloc_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_alloc_req got=%b exp=0", bus.alloc_req); end
        checks++; if (bus.dealloc_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_dealloc_req got=%b exp=0", bus.dealloc_req); end
        checks++; if (bus.dealloc_sink_id !== 4'd0) begin failures++; $display("[TB] FAIL reset_dealloc_sink_id got=%0d exp=0", bus.dealloc_sink_id); end
        checks++; if (bus.outstanding !== 5'd0) begin failures++; $display("[TB] FAIL reset_outstanding got=%0d exp=0", bus.outstanding); end
        checks++; if (bus.err_free !== 1'b0) begin failures++; $display("[TB] FAIL reset_err_free got=%b exp=0", bus.err_free); end
    endtask

    task automatic test_single_grant;
        do_reset();
        bus.alloc_sink_id = 4'd3;
        bus.req = 4'b0001;
        checks++; if (bus.alloc_req !== 1'b0) begin failures++; $display("[TB] FAIL single_alloc_req_t0 got=%b exp=0", bus.alloc_req); end
        tick();
        checks++; if (bus.alloc_req !== 1'b1) begin failures++; $display("[TB] FAIL single_alloc_req_t1 got=%b exp=1", bus.alloc_req); end
        tick();
        checks++; if (bus.alloc_req !== 1'b0) begin failures++; $display("[TB] FAIL single_alloc_req_t2 got=%b exp=0", bus.alloc_req); end
        checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("[TB] FAIL single_gnt_t2 got=%b exp=0000", bus.gnt); end
        tick();
        checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("[TB] FAIL single_gnt_t3 got=%b exp=0001", bus.gnt); end
        checks++; if (bus.gnt_sink_id !== 4'd3) begin failures++; $display("[TB] FAIL single_gnt_sink_id got=%0d exp=3", bus.gnt_sink_id); end
        bus.req = 4'b0000;
        tick();
        checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("[TB] FAIL single_gnt_t4 got=%b exp=0000", bus.gnt); end
        checks++; if (bus.outstanding !== 5'd1) begin failures++; $display("[TB] FAIL single_outstanding got=%0d exp=1", bus.outstanding); end
    endtask

    task automatic test_round_robin;
        int order [5];
        int n;
        int last;
        logic [3:0] exp_oh;
        order = '{0, 1, 2, 3, 0};
        n = 0;
        last = 0;
        do_reset();
        bus.alloc_sink_id = 4'hA;
        bus.req = 4'b1111;
        for (int c = 1; c <= 30 && n < 5; c++) begin
            tick();
            if (bus.gnt != '0) begin
                exp_oh = 4'b0001 << order[n];
                checks++; if (bus.gnt !== exp_oh) begin failures++; $display("[TB] FAIL rr_order[%0d] got=%b exp=%b", n, bus.gnt, exp_oh); end
                checks++; if (bus.gnt_sink_id !== 4'hA) begin failures++; $display("[TB] FAIL rr_sink_id[%0d] got=%0d exp=10", n, bus.gnt_sink_id); end
                checks++; if ((c - last) !== 3) begin failures++; $display("[TB] FAIL rr_spacing[%0d] got=%0d exp=3", n, c - last); end
                last = c;
                n++;
            end
        end
        bus.req = 4'b0000;
        checks++; if (n !== 5) begin failures++; $display("[TB] FAIL rr_count got=%0d exp=5", n); end
        tick();
        checks++; if (bus.outstanding !== 5'd5) begin failures++; $display("[TB] FAIL rr_outstanding got=%0d exp=5", bus.outstanding); end
    endtask

    task automatic test_full;
        int   got;
        logic saw_req;
        do_reset();
        do_grants(16, 4'b1111, 4'd0, got);
        checks++; if (got !== 16) begin failures++; $display("[TB] FAIL full_grants got=%0d exp=16", got); end
        saw_req = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.alloc_req !== 1'b0 || bus.gnt !== 4'b0000) saw_req = 1'b1;
        end
        checks++; if (saw_req !== 1'b0) begin failures++; $display("[TB] FAIL full_alloc_quiet got=%b exp=0", saw_req); end
        checks++; if (bus.outstanding !== 5'd16) begin failures++; $display("[TB] FAIL full_outstanding got=%0d exp=16", bus.outstanding); end
        bus.free_valid = 1'b1;
        bus.free_sink_id = 4'd5;
        bus.free_src = 2'd1;
        tick();
        bus.free_valid = 1'b0;
        checks++; if (bus.dealloc_req !== 1'b1) begin failures++; $display("[TB] FAIL full_dealloc_req got=%b exp=1", bus.dealloc_req); end
        checks++; if (bus.dealloc_sink_id !== 4'd5) begin failures++; $display("[TB] FAIL full_dealloc_sink_id got=%0d exp=5", bus.dealloc_sink_id); end
        checks++; if (bus.outstanding !== 5'd15) begin failures++; $display("[TB] FAIL full_after_free got=%0d exp=15", bus.outstanding); end
        checks++; if (bus.alloc_req !== 1'b0) begin failures++; $display("[TB] FAIL full_alloc_req_t1 got=%b exp=0", bus.alloc_req); end
        tick();
        checks++; if (bus.alloc_req !== 1'b1) begin failures++; $display("[TB] FAIL full_alloc_req_t2 got=%b exp=1", bus.alloc_req); end
        tick();
        tick();
        checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("[TB] FAIL full_regrant got=%b exp=0001", bus.gnt); end
        bus.req = 4'b0000;
        tick();
        checks++; if (bus.outstanding !== 5'd16) begin failures++; $display("[TB] FAIL full_refill got=%0d exp=16", bus.outstanding); end
        checks++; if (bus.err_free !== 1'b0) begin failures++; $display("[TB] FAIL full_err_free got=%b exp=0", bus.err_free); end
    endtask

    task automatic test_simultaneous;
        int got;
        do_reset();
        do_grants(7, 4'b0001, 4'd0, got);
        bus.req = 4'b0000;
        checks++; if (got !== 7) begin failures++; $display("[TB] FAIL simul_grants got=%0d exp=7", got); end
        tick();
        checks++; if (bus.outstanding !== 5'd7) begin failures++; $display("[TB] FAIL simul_pre got=%0d exp=7", bus.outstanding); end
        do_grants(1, 4'b0010, 4'd7, got);
        bus.req = 4'b0000;
        checks++; if (bus.gnt !== 4'b0010) begin failures++; $display("[TB] FAIL simul_gnt got=%b exp=0010", bus.gnt); end
        bus.free_valid = 1'b1;
        bus.free_sink_id = 4'd0;
        bus.free_src = 2'd0;
        tick();
        bus.free_valid = 1'b0;
        checks++; if (bus.outstanding !== 5'd7) begin failures++; $display("[TB] FAIL simul_outstanding got=%0d exp=7", bus.outstanding); end
        checks++; if (bus.dealloc_req !== 1'b1) begin failures++; $display("[TB] FAIL simul_dealloc_req got=%b exp=1", bus.dealloc_req); end
        checks++; if (bus.err_free !== 1'b0) begin failures++; $display("[TB] FAIL simul_err_free got=%b exp=0", bus.err_free); end
    endtask

    task automatic test_free_errors;
        int got;
        do_reset();
        bus.free_valid = 1'b1;
        bus.free_sink_id = 4'd9;
        bus.free_src = 2'd0;
        tick();
        bus.free_valid = 1'b0;
        checks++; if (bus.err_free !== 1'b1) begin failures++; $display("[TB] FAIL empty_err_free got=%b exp=1", bus.err_free); end
        checks++; if (bus.outstanding !== 5'd0) begin failures++; $display("[TB] FAIL empty_outstanding got=%0d exp=0", bus.outstanding); end
        checks++; if (bus.dealloc_sink_id !== 4'd9) begin failures++; $display("[TB] FAIL empty_dealloc_sink_id got=%0d exp=9", bus.dealloc_sink_id); end
        tick();
        checks++; if (bus.err_free !== 1'b1) begin failures++; $display("[TB] FAIL empty_err_sticky got=%b exp=1", bus.err_free); end
        do_reset();
        checks++; if (bus.err_free !== 1'b0) begin failures++; $display("[TB] FAIL empty_err_cleared got=%b exp=0", bus.err_free); end
        do_grants(1, 4'b0010, 4'd2, got);
        bus.req = 4'b0000;
        checks++; if (bus.gnt_sink_id !== 4'd2) begin failures++; $display("[TB] FAIL owner_gnt_id got=%0d exp=2", bus.gnt_sink_id); end
        tick();
        bus.free_valid = 1'b1;
        bus.free_sink_id = 4'd2;
        bus.free_src = 2'd3;
        tick();
        bus.free_valid = 1'b0;
`ifdef SINK_ARB_OWNER_CHECK_EN
        checks++; if (bus.err_free !== 1'b1) begin failures++; $display("[TB] FAIL owner_err_free got=%b exp=1", bus.err_free); end
`else
        checks++; if (bus.err_free !== 1'b0) begin failures++; $display("[TB] FAIL owner_ignored got=%b exp=0", bus.err_free); end
`endif
        checks++; if (bus.outstanding !== 5'd0) begin failures++; $display("[TB] FAIL owner_outstanding got=%0d exp=0", bus.outstanding); end
        checks++; if (bus.dealloc_sink_id !== 4'd2) begin failures++; $display("[TB] FAIL owner_dealloc_id got=%0d exp=2", bus.dealloc_sink_id); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        bus.alloc_sink_id = 4'd6;
        bus.req = 4'b0100;
        tick();
        checks++; if (bus.alloc_req !== 1'b1) begin failures++; $display("[TB] FAIL mid_alloc_req got=%b exp=1", bus.alloc_req); end
        tick();
        rst = 1'b1;
        tick();
        checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("[TB] FAIL mid_gnt got=%b exp=0000", bus.gnt); end
        checks++; if (bus.gnt_sink_id !== 4'd0) begin failures++; $display("[TB] FAIL mid_gnt_sink_id got=%0d exp=0", bus.gnt_sink_id); end
        checks++; if (bus.alloc_req !== 1'b0) begin failures++; $display("[TB] FAIL mid_alloc_req_rst got=%b exp=0", bus.alloc_req); end
        checks++; if (bus.outstanding !== 5'd0) begin failures++; $display("[TB] FAIL mid_outstanding got=%0d exp=0", bus.outstanding); end
        rst = 1'b0;
        checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("[TB] FAIL mid_gnt_r0 got=%b exp=0000", bus.gnt); end
        tick();
        checks++; if (bus.alloc_req !== 1'b1) begin failures++; $display("[TB] FAIL mid_reserve_req got=%b exp=1", bus.alloc_req); end
        tick();
        tick();
        checks++; if (bus.gnt !== 4'b0100) begin failures++; $display("[TB] FAIL mid_reserve_gnt got=%b exp=0100", bus.gnt); end
        checks++; if (bus.gnt_sink_id !== 4'd6) begin failures++; $display("[TB] FAIL mid_reserve_id got=%0d exp=6", bus.gnt_sink_id); end
        bus.req = 4'b0000;
        tick();
    endtask

    initial begin
        rst               = 1'b1;
        bus.req           = '0;
        bus.free_valid    = 1'b0;
        bus.free_sink_id  = '0;
        bus.free_src      = '0;
        bus.alloc_sink_id = '0;
        test_reset();
        test_single_grant();
        test_round_robin();
        test_full();
        test_simultaneous();
        test_free_errors();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sink_id_arbiter.md
# sink_id_arbiter

Shares the single L2-adapter sink ID allocator among `NUM_REQ` Grant-issuing requesters. The block arbitrates round-robin and sequences the allocator's request/grant handshake. It returns the allocated ID to the winning requester and forwards GrantAck-driven frees back to the allocator. It also counts outstanding IDs so the allocator is never requested when it is exhausted.

## Interface
- `NUM_REQ`, 4 — number of requesters (2..8)
- `ID_W`, 4 — sink ID width; pool size is `2**ID_W`
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `req`  in  `NUM_REQ`  per-requester request, held high until its `gnt`
- `gnt`  out  `NUM_REQ`  one-hot, one-cycle grant pulse
- `gnt_sink_id`  out  `ID_W`  ID for the granted requester, valid while `gnt` is nonzero
- `free_valid`  in  1  GrantAck received, release `free_sink_id`
- `free_sink_id`  in  `ID_W`  ID being released
- `free_src`  in  `$clog2(NUM_REQ)`  requester that owned the freed ID (used only with owner check)
- `alloc_req`  out  1  to allocator
- `alloc_gnt`  in  1  from allocator, one cycle after `alloc_req`
- `alloc_sink_id`  in  `ID_W`  allocator candidate ID; the allocated ID is the value present in the cycle `alloc_req` is high
- `dealloc_req`  out  1  to allocator
- `dealloc_sink_id`  out  `ID_W`  to allocator
- `outstanding`  out  `ID_W+1`  number of IDs currently held
- `err_free`  out  1  sticky illegal-free flag

## Operation
- FSM states are IDLE, REQ and WAIT. All outputs are registered.
- **IDLE:**
  - Eligible requesters are those with `req` high and `gnt` low in this cycle.
  - If any requester is eligible and `outstanding < 2**ID_W`, pick the winner round-robin and latch its index, then go to REQ.
- **REQ:**
  - `alloc_req` is high for exactly this cycle.
  - Capture `alloc_sink_id` into `id_q`, then go to WAIT.
- **WAIT:**
  - If `alloc_gnt` is high, next cycle `gnt[winner]` is 1, `gnt_sink_id` is `id_q`, and the round-robin pointer becomes winner+1 mod `NUM_REQ`.
  - If `alloc_gnt` is low, no grant is issued and the pointer is unchanged, so the same requester wins the retry. This path is a protocol fault by construction.
  - Either way, go to IDLE.
- **Round-robin:**
  - The search starts at the pointer and wraps modulo `NUM_REQ`.
  - The pointer resets to 0, so requester 0 has the highest priority after reset.
- **Outstanding counter:**
  - Increments on each `gnt` pulse and decrements on each accepted free.
  - A grant and a free in the same cycle leave the counter unchanged.
  - It never wraps. A free when the count is 0 does not decrement the counter and sets `err_free`.
- **Free path:**
  - `free_valid` is registered to `dealloc_req`/`dealloc_sink_id` one cycle later.
  - A free is forwarded even in the cycle `alloc_req` is high.
- **Full:**
  - When `outstanding == 2**ID_W`, the FSM stays in IDLE and every requester waits.
  - A free in cycle T makes arbitration legal from cycle T+1.
- **Reset mid-operation:**
  - The FSM returns to IDLE and the counter and pointer clear.
  - A pending grant is dropped, and the requester must keep `req` high to be served.

## Timing
- Reset values: `gnt`=0, `gnt_sink_id`=0, `alloc_req`=0, `dealloc_req`=0, `dealloc_sink_id`=0, `outstanding`=0, `err_free`=0.
- With `req` high in cycle T (IDLE), `alloc_req` is high in T+1, `alloc_gnt` is high in T+2, and `gnt` is high in T+3.
- Back-to-back throughput is one grant per 3 cycles. The next arbitration can occur in the `gnt` cycle T+3, with the granted requester masked.
- Free latency to `dealloc_req` is 1 cycle.

## Configuration
- `SINK_ARB_OWNER_CHECK_EN` defined:
  - A `2**ID_W`-entry owner table (index plus valid bit) is written on each grant.
  - On each free, the owner entry must be valid and equal to `free_src`. Otherwise `err_free` is set sticky and the free is still forwarded.
  - The valid bit is cleared when the entry is freed.
- Undefined:
  - No owner table is built and `free_src` is ignored.
  - `err_free` reports only a free when the count is 0.

## Structure
- Package `tidc_sink_pkg`:
  - `SINK_ID_W`
  - `sink_id_t`
  - FSM state enum `sink_arb_state_e`
- Sub-module `rr_arbiter`:
  - Parameterised `NUM_REQ`.
  - Inputs: request vector, pointer.
  - Outputs: one-hot winner, encoded winner index, any-winner flag.
  - Purely combinational.

## Test plan
- Reset, then `req`=4'b0001 with `alloc_sink_id`=3 in the REQ cycle → `alloc_req` high at T+1, `gnt`=4'b0001 with `gnt_sink_id`=3 at T+3, `outstanding`=1.
- `req`=4'b1111 held → grants in the order 0,1,2,3,0, spaced 3 cycles apart.
- 16 grants with no frees → `outstanding`=16 and `alloc_req` stays low. A free of ID 5 then gives `dealloc_req` high with `dealloc_sink_id`=5 one cycle later, and the next arbitration proceeds.
- `free_valid` in the same cycle as a `gnt` pulse with `outstanding`=7 → `outstanding` stays 7.
- Free when `outstanding`=0 → `err_free`=1 and `outstanding` stays 0. With `SINK_ARB_OWNER_CHECK_EN`, granting ID 2 to requester 1 and then freeing it with `free_src`=3 also sets `err_free`=1.
- Assert `rst` during WAIT → all outputs are 0 the next cycle, no `gnt` is issued, and a held `req` is re-served from IDLE.
